// File: rtl/nes_pkg.sv
// Shared definitions for the NES controller emulator and the NES receiver:
// button indices, FSM state encoding and frame width.
package nes_pkg;

  localparam int NES_BITS   = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    SHIFT   = 2'd2
  } nes_state_e;

  // Bit counter that sticks at NES_BITS once the whole frame has gone out.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= 4'(NES_BITS)) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/nes_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus an edge-detect flop
// producing one-cycle rise/fall pulses in the clk domain.
module nes_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/nes_controller_emulator.sv
// Responder side of the NES pad protocol (4021 emulation): latch buttons,
// shift them out on nes_clk. Optional autofire on A/B under NES_TURBO_EN.
module nes_controller_emulator
  import nes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TURBO_DIV      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] buttons,
`ifdef NES_TURBO_EN
  input  logic [1:0] turbo_mask,
`endif
  input  logic       nes_latch,
  input  logic       nes_clk,
  output logic       nes_data,
  output logic       frame_strobe,
  output logic [3:0] bit_count,
  output logic       busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

  logic latch_lvl, latch_rise, latch_fall;
  logic clk_lvl, clk_rise, clk_fall;

  nes_sync_edge u_sync_latch (
    .clk(clk), .rst_n(rst_n), .async_i(nes_latch),
    .level_o(latch_lvl), .rise_o(latch_rise), .fall_o(latch_fall)
  );

  nes_sync_edge u_sync_clk (
    .clk(clk), .rst_n(rst_n), .async_i(nes_clk),
    .level_o(clk_lvl), .rise_o(clk_rise), .fall_o(clk_fall)
  );

  nes_state_e state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic strobe_q, strobe_d;
  logic [7:0] load_val;

`ifdef NES_TURBO_EN
  logic [7:0] frame_cnt_q;

  always_comb begin
    load_val = buttons;
    for (int k = 0; k < 2; k++)
      load_val[k] = buttons[k] & (~turbo_mask[k] | frame_cnt_q[TURBO_DIV]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        frame_cnt_q <= 8'd0;
    else if (strobe_d) frame_cnt_q <= frame_cnt_q + 8'd1;
  end
`else
  assign load_val = buttons;
`endif

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    strobe_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (latch_lvl) state_d = LOADING;
      end
      LOADING: begin
        // Keep sampling until the synced latch falls; that cycle's sample is final.
        shift_d = load_val;
        cnt_d   = 4'd0;
        tmo_d   = '0;
        if (latch_fall) begin
          state_d  = SHIFT;
          strobe_d = 1'b1;
        end
      end
      SHIFT: begin
        if (latch_rise) begin
          state_d = LOADING;
        end else if (clk_rise) begin
          shift_d = {1'b1, shift_q[7:1]};
          cnt_d   = sat_inc(cnt_q);
          tmo_d   = '0;
        end else if (tmo_q == TMO_MAX) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= 8'h00;
      cnt_q    <= 4'd0;
      tmo_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      strobe_q <= strobe_d;
    end
  end

  assign nes_data     = (state_q == IDLE) ? 1'b1 : ~shift_q[0];
  assign frame_strobe = strobe_q;
  assign bit_count    = cnt_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_nes_controller_emulator.sv
// Directed bench for nes_controller_emulator; turbo scenario runs only when
// NES_TURBO_EN is defined.
module tb_nes_controller_emulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] buttons;
  logic       nes_latch;
  logic       nes_clk;
  logic       nes_data;
  logic       frame_strobe;
  logic [3:0] bit_count;
  logic       busy;
`ifdef NES_TURBO_EN
  logic [1:0] turbo_mask;
`endif

  int n_pass = 0;
  int n_tot  = 0;
  int fs_cnt = 0;

  always #5 clk = ~clk;

  nes_controller_emulator #(.TIMEOUT_CYCLES(16), .TURBO_DIV(0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .buttons(buttons),
`ifdef NES_TURBO_EN
    .turbo_mask(turbo_mask),
`endif
    .nes_latch(nes_latch),
    .nes_clk(nes_clk),
    .nes_data(nes_data),
    .frame_strobe(frame_strobe),
    .bit_count(bit_count),
    .busy(busy)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (frame_strobe === 1'b1) fs_cnt++;
    end
  endtask

  task automatic latch_frame();
    nes_latch = 1'b1;
    tick(12);
    nes_latch = 1'b0;
    tick(6);
  endtask

  task automatic clk_pulse();
    nes_clk = 1'b1;
    tick(6);
    nes_clk = 1'b0;
    tick(6);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; buttons = 8'h00; nes_latch = 1'b0; nes_clk = 1'b0;
    tick(2);
    n_tot++; if (nes_data !== 1'b1) $display("FAIL rst_data got=%0b exp=1", nes_data); else n_pass++;
    n_tot++; if (busy !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", busy); else n_pass++;
    n_tot++; if (bit_count !== 4'd0) $display("FAIL rst_count got=%0d exp=0", bit_count); else n_pass++;
    n_tot++; if (frame_strobe !== 1'b0) $display("FAIL rst_strobe got=%0b exp=0", frame_strobe); else n_pass++;
    rst_n = 1'b1;
    tick(2);
    // Reset mid-SHIFT
    buttons = 8'h01;
    latch_frame();
    clk_pulse();
    clk_pulse();
    n_tot++; if (bit_count !== 4'd2) $display("FAIL pre_rst_count got=%0d exp=2", bit_count); else n_pass++;
    rst_n = 1'b0;
    tick(2);
    n_tot++; if (nes_data !== 1'b1) $display("FAIL mid_rst_data got=%0b exp=1", nes_data); else n_pass++;
    n_tot++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got=%0b exp=0", busy); else n_pass++;
    n_tot++; if (bit_count !== 4'd0) $display("FAIL mid_rst_count got=%0d exp=0", bit_count); else n_pass++;
    rst_n = 1'b1;
    clk_pulse();
    n_tot++; if (bit_count !== 4'd0) $display("FAIL idle_clk_count got=%0d exp=0", bit_count); else n_pass++;
    n_tot++; if (nes_data !== 1'b1) $display("FAIL idle_clk_data got=%0b exp=1", nes_data); else n_pass++;
  endtask

  task automatic test_basic_read();
    logic [7:0] exp_seq;
    exp_seq = 8'b0111_1110;  // LSB first: A pressed, Right pressed
    buttons = 8'b1000_0001;
    fs_cnt = 0;
    nes_latch = 1'b1;
    tick(12);
    n_tot++; if (busy !== 1'b1) $display("FAIL load_busy got=%0b exp=1", busy); else n_pass++;
    n_tot++; if (nes_data !== 1'b0) $display("FAIL load_data got=%0b exp=0", nes_data); else n_pass++;
    nes_latch = 1'b0;
    tick(2);
    n_tot++; if (frame_strobe !== 1'b0) $display("FAIL strobe_early got=%0b exp=0", frame_strobe); else n_pass++;
    tick(1);
    n_tot++; if (frame_strobe !== 1'b1) $display("FAIL strobe_at3 got=%0b exp=1", frame_strobe); else n_pass++;
    tick(1);
    n_tot++; if (frame_strobe !== 1'b0) $display("FAIL strobe_late got=%0b exp=0", frame_strobe); else n_pass++;
    tick(2);
    n_tot++; if (nes_data !== exp_seq[0]) $display("FAIL read_bit0 got=%0b exp=%0b", nes_data, exp_seq[0]); else n_pass++;
    for (int k = 1; k <= 8; k++) begin
      clk_pulse();
      if (k < 8) begin
        n_tot++; if (nes_data !== exp_seq[k]) $display("FAIL read_bit%0d got=%0b exp=%0b", k, nes_data, exp_seq[k]); else n_pass++;
      end else begin
        n_tot++; if (nes_data !== 1'b0) $display("FAIL read_fill got=%0b exp=0", nes_data); else n_pass++;
      end
      n_tot++; if (bit_count !== 4'(k)) $display("FAIL read_count%0d got=%0d exp=%0d", k, bit_count, k); else n_pass++;
    end
    n_tot++; if (fs_cnt !== 1) $display("FAIL strobe_count got=%0d exp=1", fs_cnt); else n_pass++;
  endtask

  task automatic test_overrun();
    buttons = 8'h00;
    latch_frame();
    n_tot++; if (nes_data !== 1'b1) $display("FAIL ovr_bit0 got=%0b exp=1", nes_data); else n_pass++;
    for (int k = 1; k <= 10; k++) begin
      clk_pulse();
      if (k == 7) begin
        n_tot++; if (nes_data !== 1'b1) $display("FAIL ovr_bit7 got=%0b exp=1", nes_data); else n_pass++;
      end
      if (k >= 8) begin
        n_tot++; if (nes_data !== 1'b0) $display("FAIL ovr_data%0d got=%0b exp=0", k, nes_data); else n_pass++;
        n_tot++; if (bit_count !== 4'd8) $display("FAIL ovr_count%0d got=%0d exp=8", k, bit_count); else n_pass++;
      end
    end
  endtask

  task automatic test_button_change();
    logic [7:0] exp_seq;
    exp_seq = 8'hC3;  // ~8'h3C, the value present when the synced latch falls
    buttons = 8'h0F;
    nes_latch = 1'b1;
    tick(4);
    buttons = 8'hA5;
    tick(8);
    nes_latch = 1'b0;
    tick(1);
    buttons = 8'h3C;
    tick(5);
    buttons = 8'hFF;
    n_tot++; if (nes_data !== exp_seq[0]) $display("FAIL chg_bit0 got=%0b exp=%0b", nes_data, exp_seq[0]); else n_pass++;
    for (int k = 1; k < 8; k++) begin
      clk_pulse();
      n_tot++; if (nes_data !== exp_seq[k]) $display("FAIL chg_bit%0d got=%0b exp=%0b", k, nes_data, exp_seq[k]); else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    buttons = 8'h02;
    latch_frame();
    clk_pulse();
    clk_pulse();
    n_tot++; if (bit_count !== 4'd2) $display("FAIL sim_pre_count got=%0d exp=2", bit_count); else n_pass++;
    nes_latch = 1'b1;
    nes_clk = 1'b1;
    tick(3);
    n_tot++; if (bit_count !== 4'd2) $display("FAIL sim_no_shift got=%0d exp=2", bit_count); else n_pass++;
    tick(1);
    n_tot++; if (bit_count !== 4'd0) $display("FAIL sim_count got=%0d exp=0", bit_count); else n_pass++;
    n_tot++; if (busy !== 1'b1) $display("FAIL sim_busy got=%0b exp=1", busy); else n_pass++;
    nes_clk = 1'b0;
    tick(4);
    nes_latch = 1'b0;
    tick(6);
    n_tot++; if (nes_data !== 1'b1) $display("FAIL sim_bit0 got=%0b exp=1", nes_data); else n_pass++;
    clk_pulse();
    n_tot++; if (nes_data !== 1'b0) $display("FAIL sim_bit1 got=%0b exp=0", nes_data); else n_pass++;
  endtask

  task automatic test_timeout();
    buttons = 8'h01;
    nes_latch = 1'b1;
    tick(12);
    nes_latch = 1'b0;
    tick(3);
    n_tot++; if (frame_strobe !== 1'b1) $display("FAIL tmo_strobe got=%0b exp=1", frame_strobe); else n_pass++;
    tick(15);
    n_tot++; if (busy !== 1'b1) $display("FAIL tmo_c15_busy got=%0b exp=1", busy); else n_pass++;
    n_tot++; if (nes_data !== 1'b0) $display("FAIL tmo_c15_data got=%0b exp=0", nes_data); else n_pass++;
    tick(1);
    n_tot++; if (busy !== 1'b0) $display("FAIL tmo_c16_busy got=%0b exp=0", busy); else n_pass++;
    n_tot++; if (nes_data !== 1'b1) $display("FAIL tmo_c16_data got=%0b exp=1", nes_data); else n_pass++;
    latch_frame();
    clk_pulse();
    clk_pulse();
    tick(30);
    n_tot++; if (busy !== 1'b0) $display("FAIL tmo2_busy got=%0b exp=0", busy); else n_pass++;
    n_tot++; if (bit_count !== 4'd2) $display("FAIL tmo2_count got=%0d exp=2", bit_count); else n_pass++;
    n_tot++; if (nes_data !== 1'b1) $display("FAIL tmo2_data got=%0b exp=1", nes_data); else n_pass++;
    clk_pulse();
    n_tot++; if (bit_count !== 4'd2) $display("FAIL tmo2_idle_clk got=%0d exp=2", bit_count); else n_pass++;
  endtask

`ifdef NES_TURBO_EN
  task automatic test_turbo();
    logic [3:0] exp_first;
    exp_first = 4'b0101;  // frame 0..3 first bit: 1,0,1,0
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    turbo_mask = 2'b01;
    buttons = 8'h01;
    for (int f = 0; f < 4; f++) begin
      latch_frame();
      n_tot++; if (nes_data !== exp_first[f]) $display("FAIL turbo_f%0d got=%0b exp=%0b", f, nes_data, exp_first[f]); else n_pass++;
    end
    turbo_mask = 2'b00;
  endtask
`endif

  initial begin
`ifdef NES_TURBO_EN
    turbo_mask = 2'b00;
`endif
    test_reset();
    test_basic_read();
    test_overrun();
    test_button_change();
    test_simultaneous();
    test_timeout();
`ifdef NES_TURBO_EN
    test_turbo();
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
